// File: rtl/mem_access_pkg.sv
// Shared constants for the load/store unit: FSM state encoding, access sizes
// and the operation legality rule.
package mem_access_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  // Exactly one of ld/st, a defined size, and natural alignment for that size.
  function automatic logic op_legal(input logic ld, input logic st,
                                    input logic [1:0] size, input logic [2:0] off);
    logic aligned;
    case (size)
      SZ_B:    aligned = 1'b1;
      SZ_W:    aligned = (off[1:0] == 2'b00);
      SZ_D:    aligned = (off == 3'b000);
      default: aligned = 1'b0;
    endcase
    return (ld ^ st) & aligned;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the load/store unit (master)
// and the memory (slave).
interface mem_access_if #(
  parameter int AW = 64
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_be;
  logic [63:0]   mem_wdata;
  logic          mem_ack;
  logic [63:0]   mem_rdata;

  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_lane.sv
// Combinational lane logic for a 64-bit data bus: byte enables, store-data
// shift into lanes and right-aligned, zero-filled load-data extraction.
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [2:0]  off_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  be_o,
  output logic [63:0] wdata_o,
  output logic [63:0] rdata_o
);

  logic [5:0]  shamt;
  logic [63:0] rd_shifted;

  assign shamt      = {off_i, 3'b000};
  assign rd_shifted = rdata_i >> shamt;
  assign wdata_o    = wdata_i << shamt;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    be_o    = 8'hFF;
    rdata_o = rd_shifted;
    case (size_i)
      SZ_B: begin
        be_o    = 8'h01 << off_i;
        rdata_o = {56'h0, rd_shifted[7:0]};
      end
      SZ_W: begin
        be_o    = 8'h0F << off_i;
        rdata_o = {32'h0, rd_shifted[31:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Execute-stage load/store unit: one request/acknowledge transaction per op.
// Optional bus timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int AW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          ld,
  input  logic          st,
  input  logic [1:0]    size,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [63:0]   d,
  mem_access_if.master  mem
);

  logic [1:0]    state_q, state_d;
  logic          ld_q, ld_d;
  logic [1:0]    size_q, size_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic [63:0]   d_q, d_d;

  logic          req;
  logic [7:0]    lane_be;
  logic [63:0]   lane_wdata, lane_rdata;

  mem_lane u_lane (
    .size_i  (size_q),
    .off_i   (addr_q[2:0]),
    .wdata_i (wdata_q),
    .rdata_i (mem.mem_rdata),
    .be_o    (lane_be),
    .wdata_o (lane_wdata),
    .rdata_o (lane_rdata)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timed_out;

  assign cnt_d     = req ? cnt_q + CW'(1) : '0;
  assign timed_out = req & (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT != 0);
`endif

  // An illegal op still spends one cycle in REQ (with the bus gated off) so
  // that done/err line up with the minimum two-cycle latency.
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    d_d     = d_q;
    case (state_q)
      ST_IDLE: if (start) begin
        ld_d    = ld;
        size_d  = size;
        addr_d  = addr;
        wdata_d = wdata;
        err_d   = ~op_legal(ld, st, size, addr[2:0]);
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (err_q) begin
          state_d = ST_DONE;
        end else if (mem.mem_ack) begin
          if (ld_q) d_d = lane_rdata;
          state_d = ST_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments; reset is synchronous.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ld_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      d_q     <= d_d;
    end
  end

  assign busy = (state_q == ST_REQ);
  assign done = (state_q == ST_DONE);
  assign err  = done & err_q;
  assign d    = d_q;
  assign req  = busy & ~err_q;

  // Bus outputs are zero whenever no request is outstanding.
  assign mem.mem_req   = req;
  assign mem.mem_we    = req & ~ld_q;
  assign mem.mem_addr  = req ? {addr_q[AW-1:3], 3'b000} : '0;
  assign mem.mem_be    = req ? lane_be : '0;
  assign mem.mem_wdata = req ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_access.sv
// Randomised and directed bench for mem_access against a byte-level model.
// Define MEM_TIMEOUT_EN for both RTL and bench to exercise the timeout path.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ld, st;
  logic [1:0]  size;
  logic [63:0] addr, wdata;
  logic        busy, done, err;
  logic [63:0] d;

  int n_vec = 0;
  int n_bad = 0;
  logic [63:0] exp_d = '0;

  mem_access_if #(.AW(64)) bus ();

  mem_access #(.AW(64), .TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .ld    (ld),
    .st    (st),
    .size  (size),
    .addr  (addr),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .d     (d),
    .mem   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req_v);
    n_vec++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req_v);
    end
  endtask

  // One complete operation; wait_n = cycles between mem_req rising and mem_ack.
  task automatic do_op(input logic ld_v, input logic st_v, input logic [1:0] sz,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                       input int wait_n, input string tag);
    int          nb;
    int          off;
    logic        legal;
    logic [7:0]  ebe;
    logic [63:0] ed;
    off   = int'(a[2:0]);
    nb    = (sz == 2'd0) ? 1 : (sz == 2'd2) ? 4 : 8;
    legal = (ld_v != st_v) && (sz != 2'd1) && ((a % nb) == 0);
    ebe   = '0;
    ed    = '0;
    if (legal)
      for (int i = 0; i < nb; i++) begin
        ebe[off + i]   = 1'b1;
        ed[i*8 +: 8]   = rd[(off + i)*8 +: 8];
      end

    start = 1'b1; ld = ld_v; st = st_v; size = sz; addr = a; wdata = wd;
    step();
    start = 1'b0; ld = 1'($urandom); st = 1'($urandom);
    size = 2'($urandom); addr = {$urandom, $urandom}; wdata = {$urandom, $urandom};
    cmp({tag, " busy@1"}, 64'(busy), 64'd1);
    cmp({tag, " req@1"}, 64'(bus.mem_req), 64'(legal));
    if (legal) begin
      cmp({tag, " we"}, 64'(bus.mem_we), 64'(st_v));
      cmp({tag, " addr"}, bus.mem_addr, a & ~64'h7);
      cmp({tag, " be"}, 64'(bus.mem_be), 64'(ebe));
      cmp({tag, " wdata"}, bus.mem_wdata, wd << (8 * off));
      for (int w = 0; w < wait_n; w++) begin
        step();
        cmp({tag, " req held"}, {bus.mem_req, bus.mem_addr[62:0]}, {1'b1, a[62:3], 3'b000});
      end
      bus.mem_ack = 1'b1; bus.mem_rdata = rd;
      cmp({tag, " done early"}, 64'(done), 64'd0);
      step();
      bus.mem_ack = 1'b0; bus.mem_rdata = {$urandom, $urandom};
      if (ld_v) exp_d = ed;
    end else begin
      step();
    end
    cmp({tag, " done"}, 64'(done), 64'd1);
    cmp({tag, " err"}, 64'(err), 64'(!legal));
    cmp({tag, " req low"}, 64'(bus.mem_req), 64'd0);
    cmp({tag, " d"}, d, exp_d);
    step();
    cmp({tag, " idle"}, {62'd0, done, busy}, 64'd0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; ld = 0; st = 0; size = 0; addr = 0; wdata = 0;
    bus.mem_ack = 0; bus.mem_rdata = 0;
    step(); step();
    cmp("reset ctrl", {59'd0, busy, done, err, bus.mem_req, bus.mem_we}, 64'd0);
    cmp("reset bus", bus.mem_addr | bus.mem_wdata | 64'(bus.mem_be), 64'd0);
    cmp("reset d", d, 64'd0);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    do_op(1, 0, 2'd3, 64'h10, 64'h0, 64'h1122334455667788, 3, "ld8");
    cmp("ld8 d value", d, 64'h1122334455667788);
    do_op(1, 0, 2'd0, 64'h23, 64'h0, 64'h00000000F1000000, 0, "ld1");
    cmp("ld1 d value", d, 64'h00000000000000F1);
    do_op(0, 1, 2'd2, 64'h44, 64'hDEADBEEF, 64'h0, 0, "st4");
    cmp("st4 d kept", d, 64'h00000000000000F1);
  endtask

  task automatic test_illegal();
    do_op(1, 0, 2'd2, 64'h2, 64'h0, 64'hFFFF, 0, "ill_misalign");
    do_op(1, 0, 2'd1, 64'h8, 64'h0, 64'hFFFF, 0, "ill_size");
    do_op(1, 1, 2'd3, 64'h8, 64'h0, 64'hFFFF, 0, "ill_ldst");
    do_op(0, 0, 2'd0, 64'h8, 64'h0, 64'hFFFF, 0, "ill_none");
    do_op(0, 1, 2'd3, 64'h4, 64'h5, 64'hFFFF, 0, "ill_st8");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      logic        lv, sv;
      logic [1:0]  sz;
      logic [63:0] a;
      int          kind;
      kind = int'($urandom_range(0, 9));
      lv = (kind < 5); sv = (kind >= 5 && kind < 9);
      if (kind == 9) begin lv = 1'($urandom); sv = lv; end
      sz = 2'($urandom);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[2:0] = (sz == 2'd3) ? 3'd0 : (sz == 2'd2) ? {a[2], 2'b00} : a[2:0];
      do_op(lv, sv, sz, a, {$urandom, $urandom}, {$urandom, $urandom},
            int'($urandom_range(0, 3)), "rand");
    end
  endtask

  task automatic test_ack_outside_req();
    bus.mem_ack = 1'b1; bus.mem_rdata = ~exp_d;
    step(); step();
    bus.mem_ack = 1'b0;
    cmp("stray ack d", d, exp_d);
    cmp("stray ack ctrl", {61'd0, done, busy, bus.mem_req}, 64'd0);
  endtask

  task automatic test_busy_and_reset();
    logic [63:0] rd;
    rd = {$urandom, $urandom} | 64'h1;
    start = 1; ld = 1; st = 0; size = 2'd3; addr = 64'h100;
    step();
    start = 0;
    cmp("b2b req", 64'(bus.mem_req), 64'd1);
    start = 1; ld = 0; st = 1; size = 2'd0; addr = 64'h207;
    step();
    start = 0; bus.mem_ack = 1'b1; bus.mem_rdata = rd;
    cmp("b2b op kept", {bus.mem_we, bus.mem_addr[62:0]}, 64'h100);
    step();
    bus.mem_ack = 1'b0;
    exp_d = rd;
    cmp("b2b done", {62'd0, done, err}, 64'd2);
    cmp("b2b d", d, exp_d);
    for (int i = 0; i < 3; i++) begin
      step();
      cmp("b2b not queued", {62'd0, busy, bus.mem_req}, 64'd0);
    end
    start = 1; ld = 1; st = 0; size = 2'd3; addr = 64'h300;
    step();
    start = 0;
    step();
    start = 1;
    step();
    start = 0;
    cmp("pre-reset req", 64'(bus.mem_req), 64'd1);
    rst_n = 1'b0;
    step();
    exp_d = '0;
    cmp("midreset ctrl", {59'd0, busy, done, err, bus.mem_req, bus.mem_we}, 64'd0);
    cmp("midreset bus", bus.mem_addr | bus.mem_wdata | 64'(bus.mem_be), 64'd0);
    cmp("midreset d", d, exp_d);
    rst_n = 1'b1;
    step(); step();
    cmp("post-reset idle", {62'd0, busy, bus.mem_req}, 64'd0);
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    do_op(1, 0, 2'd3, 64'h40, 64'h0, 64'hCAFEF00D12345678, 0, "pre_to");
    start = 1; ld = 1; st = 0; size = 2'd3; addr = 64'h48;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      cmp("to req", 64'(bus.mem_req), 64'd1);
      step();
    end
    cmp("to req drop", 64'(bus.mem_req), 64'd0);
    cmp("to done err", {62'd0, done, err}, 64'd3);
    cmp("to d kept", d, exp_d);
    step();
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_random();
    test_ack_outside_req();
    test_busy_and_reset();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Load/store unit of the execute stage. Takes a single memory operation from control, runs one request/acknowledge transaction on the data-memory bus, and presents right-aligned, zero-filled load data on `d` for the result selector. The selector owns all sign/zero extension; this block only does lane alignment, byte enables, misalignment checking and bus sequencing.

## Interface
Parameters:
- `AW`, 64, byte-address width
- `TIMEOUT`, 255, max cycles waiting for `mem_ack` (used only with timeout feature)

Ports:
- `clk`  in  1  clock; single clock domain
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle request strobe; sampled only in IDLE
- `ld`  in  1  operation is a load
- `st`  in  1  operation is a store
- `size`  in  2  0 = 1 byte, 2 = 4 bytes, 3 = 8 bytes; 1 reserved
- `addr`  in  AW  byte address
- `wdata`  in  64  store data, right-aligned
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`: misaligned, illegal or timed-out op
- `d`  out  64  load data, right-aligned, upper bytes zero; held until next successful load
- `mem_req`  out  1  bus request, held until acknowledged
- `mem_we`  out  1  1 = write
- `mem_addr`  out  AW  `addr` with bits [2:0] cleared
- `mem_be`  out  8  byte enables
- `mem_wdata`  out  64  store data shifted into lanes
- `mem_ack`  in  1  bus acknowledge; `mem_rdata` valid in the same cycle
- `mem_rdata`  in  64  bus read data

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE: on `start`, registers `ld/st/size/addr/wdata`, then checks legality:
  - legal: exactly one of `ld`/`st`, `size` not 1, aligned (4B: `addr[1:0]`=0; 8B: `addr[2:0]`=0) -> REQ.
  - illegal -> DONE with `err`=1; no bus activity.
- REQ: `mem_req`=1, with `mem_we/mem_addr/mem_be/mem_wdata` stable. On `mem_ack`:
  - load: extract lanes starting at `addr[2:0]`, zero the rest, write into `d`;
  - go to DONE.
- DONE: `done`=1 for one cycle, `err` set per outcome; then IDLE.
- Byte enables:
  - 1B: `8'b1 << addr[2:0]`
  - 4B: `8'hF << addr[2:0]`
  - 8B: `8'hFF`
- `mem_wdata` = `wdata << (8*addr[2:0])`.
- `d` is not modified by stores, errors or timeouts.
- `start` outside IDLE is ignored: not queued, no error.

## Timing
- Reset: state IDLE; `busy`, `done`, `err`, `mem_req`, `mem_we` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `d` = 0.
- `start` at cycle 0 -> `mem_req` and `busy` high at cycle 1.
- Ack at cycle N (N ≥ 1):
  - `mem_req` low at N+1;
  - `done` high at N+1;
  - `d` updated at the same edge as `done` rises.
- Minimum latency: 2 cycles from `start` to `done`.
- Illegal op: `done` and `err` at cycle 2; `mem_req` never rises.
- `mem_ack` outside REQ is ignored.
- Reset asserted mid-transaction: all outputs return to their reset values at the next edge, including `mem_req`, which drops immediately. The bus must tolerate an abandoned request.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - a counter runs in REQ;
  - when it reaches `TIMEOUT` cycles without `mem_ack`, `mem_req` drops and the FSM enters DONE with `err`=1.
  - `d` is untouched.
- `MEM_TIMEOUT_EN` undefined: no counter; REQ waits indefinitely.

## Structure
- Shared package/include holds:
  - state encoding (IDLE=0, REQ=1, DONE=2);
  - size constants (`SZ_B`=0, `SZ_W`=2, `SZ_D`=3).
- One combinational sub-module, `mem_lane`:
  - byte-enable generation, write-data shift and read-data extraction from `size`/`addr[2:0]`;
  - reused by any future fetch or DMA path.

## Test plan
- Load 8B, `addr`=0x10, ack after 3 wait cycles, `mem_rdata`=0x1122334455667788 -> `mem_addr`=0x10, `mem_be`=0xFF, `d`=0x1122334455667788, `err`=0, `done` 5 cycles after `start`.
- Load 1B, `addr`=0x23, `mem_rdata`=0x00000000F1000000 -> `mem_be`=0x08, `d`=0x00000000000000F1.
- Store 4B, `addr`=0x44, `wdata`=0xDEADBEEF, ack same cycle as req -> `mem_we`=1, `mem_be`=0xF0, `mem_wdata`=0xDEADBEEF00000000, `done` at cycle 2, `d` unchanged.
- Illegal ops: 4B load at `addr`=0x2; `size`=1; `ld`=`st`=1 -> each gives `done`+`err` at cycle 2 with no `mem_req`.
- `start` pulsed while busy, then reset asserted during REQ -> second `start` ignored; `mem_req`=0 and all outputs at reset values the cycle after reset.
- With `MEM_TIMEOUT_EN`, `TIMEOUT`=4, no ack -> `mem_req` drops after 4 REQ cycles, `done`=`err`=1; prior `d` retained.
